reg_q_piso_ctrl: RTL and testbench
==================================

# reg_q_piso_ctrl

Multiplier register Q for the shift-add multiplier datapath, the consuming side of the multiplicand register B. It loads the multiplier word in parallel and presents it one bit at a time, LSB first, to the add/shift control. On every accepted step it shifts in a serial bit at the MSB, normally the accumulator LSB. A bit counter and a small FSM report busy and completion, so when the block finishes, Q holds the low half of the product.

## Interface
- `BITS`, default 8: multiplier width; the counter width is `CNT_W = $clog2(BITS+1)`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `start`  in  1  load request; sampled only in IDLE.
- `DP`  in  BITS  parallel multiplier word, captured on the accepted `start`.
- `SI`  in  1  serial input shifted into the MSB on each step.
- `step`  in  1  downstream has consumed `q0`; advance one bit.
- `q0`  out  1  current LSB of Q; meaningful while `q0_valid`=1.
- `q0_valid`  out  1  high in SHIFT.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `out`  out  BITS  current Q contents.
- `count`  out  CNT_W  bits remaining to shift.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:** `start`=1 loads `DP` into Q, sets `count`=BITS and moves to SHIFT. With `start`=0, Q and `count` hold.
- **SHIFT:** `q0`=Q[0] and `q0_valid`=1.
  - `step`=1 sets Q <= {SI, Q[BITS-1:1]} and decrements `count`.
  - A step taken with `count`==1 moves to DONE.
  - `step`=0 holds Q, `count` and `q0`. There is no timeout.
- **DONE:** `done`=1 for exactly one cycle, then unconditional return to IDLE. Q holds the final shifted value until the next load.
- `start` is ignored in SHIFT and DONE; it is not queued, so the requester must re-assert it in IDLE.
- `step` is ignored in IDLE and DONE.
- **Reset:** asserting `rst`=0 at any time, including mid-SHIFT, forces IDLE with Q=0 and `count`=0. All outputs become 0 (`q0`, `q0_valid`, `busy`, `done`, `out`, `count`) with no clock edge required. The first edge after release may accept `start`.
- **Width rules:** `count` never underflows; it only decrements in SHIFT, where it is at least 1. `out` is exactly BITS wide, and `SI` enters at bit BITS-1.

## Timing
- A `start` accepted at edge k gives SHIFT, `q0_valid`=1 and `q0`=DP[0] after edge k.
- With `step` held at 1, the BITS-th shift occurs at edge k+BITS. `done` is high during cycle k+BITS+1 and IDLE resumes after edge k+BITS+1.
- **Minimum start-to-start spacing:** BITS+2 cycles.
- **Outputs:** all are registered-state decodes, with no combinational path from inputs to outputs.
- **`step` handshake:** each accepted step changes `q0` on the following cycle, so the consumer samples `q0` in the same cycle it asserts `step`.

## Structure
- **Shared package `mult_pkg`:**
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} q_state_t`.
  - A `CNT_W` helper function.
  - The `BITS` default, shared with the B and A registers.
- **One sub-module, `down_counter_en`:** loadable, enabled down-counter holding `count`, with a `zero_next` flag.
- The FSM and the shift register stay in the top module.

## Test plan
- **Full run, SI=0:** BITS=8, `DP`=8'hB5, `SI`=0, `step`=1 continuously, pulse `start`. Expect `q0` sequence 1,0,1,0,1,1,0,1 over 8 cycles, `done` in cycle 9, then `out`=8'h00 and `count`=0.
- **Full run, SI=1:** same as above but `SI`=1 throughout. Expect final `out`=8'hFF and `done` exactly one cycle.
- **Step gaps:** `DP`=8'h03, `step` pattern 1,0,0,1,1,0,1... Expect `q0` and `count` to hold on `step`=0 cycles, and `done` only after the 8th accepted step.
- **Reset mid-operation:** `rst`=0 after 3 shifts of `DP`=8'hF0. Expect immediate `out`=0, `count`=0 and `busy`=0. A new `start` with `DP`=8'h5A then yields `q0`=0 on the next cycle.
- **Start while busy:** `start`=1 with `DP`=8'h11 in SHIFT and again in DONE. Expect Q unaffected, with no reload until IDLE.
- **Back-to-back starts:** `start` re-asserted in the first IDLE cycle after `done`. Expect a load, and starts spaced exactly BITS+2 cycles apart.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier registers (B, Q, A).
package mult_pkg;

  localparam int unsigned BITS_DEF = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} q_state_t;

  // Width needed to hold the values 0..bits inclusive.
  function automatic int unsigned cnt_w(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/down_counter_en.sv
// Loadable, enabled down-counter; zero_next flags that an enabled decrement reaches zero.
module down_counter_en #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] count,
  output logic         zero_next
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= d;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_next = en && !load && (count == W'(1));

endmodule

// File: rtl/reg_q_piso_ctrl.sv
// Multiplier register Q: parallel load, LSB-first serial presentation,
// serial fill at the MSB, with bit counter and IDLE/SHIFT/DONE control.
module reg_q_piso_ctrl
  import mult_pkg::*;
#(
  parameter  int unsigned BITS  = BITS_DEF,
  localparam int unsigned CNT_W = cnt_w(BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BITS-1:0]  DP,
  input  logic             SI,
  input  logic             step,
  output logic             q0,
  output logic             q0_valid,
  output logic             busy,
  output logic             done,
  output logic [BITS-1:0]  out,
  output logic [CNT_W-1:0] count
);

  q_state_t        state, state_nx;
  logic [BITS-1:0] q;
  logic            load, shift_en, zero_next;

  down_counter_en #(
    .W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (shift_en),
    .d         (CNT_W'(BITS)),
    .count     (count),
    .zero_next (zero_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        q <= DP;
      end else if (shift_en) begin
        q <= {SI, q[BITS-1:1]};
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (step) begin
          shift_en = 1'b1;
          if (zero_next) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign q0       = q[0];
  assign q0_valid = (state == SHIFT);
  assign busy     = (state == SHIFT) || (state == DONE);
  assign done     = (state == DONE);
  assign out      = q;

endmodule

// File: tb/tb_reg_q_piso_ctrl.sv
// Directed self-checking bench for reg_q_piso_ctrl (BITS=8).
module tb_reg_q_piso_ctrl;

  localparam int unsigned BITS  = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BITS-1:0]  DP;
  logic             SI;
  logic             step;
  logic             q0;
  logic             q0_valid;
  logic             busy;
  logic             done;
  logic [BITS-1:0]  out;
  logic [CNT_W-1:0] count;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;

  reg_q_piso_ctrl #(
    .BITS (BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .DP       (DP),
    .SI       (SI),
    .step     (step),
    .q0       (q0),
    .q0_valid (q0_valid),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  b5_seq;
  logic [12:0] gap_pat;
  logic [7:0]  qm;
  logic [3:0]  cm;
  int unsigned cyc_a, cyc_b;
  bit          seen;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    DP    = '0;
    SI    = 1'b0;
    step  = 1'b0;

    // Reset state
    #12;
    chk("rst_out", out, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", q0_valid, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // Full run, SI=0, DP=B5: q0 = 1,0,1,0,1,1,0,1
    b5_seq = 8'b1011_0101;   // bit i = expected q0 in shift cycle i
    DP = 8'hB5; SI = 1'b0; step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("r0_count_load", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r0_q0_%0d", i), q0, b5_seq[i]);
      chk($sformatf("r0_valid_%0d", i), q0_valid, 1);
      chk($sformatf("r0_done_early_%0d", i), done, 0);
      tick();
    end
    chk("r0_done", done, 1);
    chk("r0_busy_done", busy, 1);
    chk("r0_out", out, 8'h00);
    chk("r0_count", count, 0);
    tick();
    chk("r0_done_clear", done, 0);
    chk("r0_idle_busy", busy, 0);
    chk("r0_idle_out", out, 8'h00);

    // Full run, SI=1: final out = FF, done one cycle
    DP = 8'hB5; SI = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("r1_done", done, 1);
    chk("r1_out", out, 8'hFF);
    tick();
    chk("r1_done_once", done, 0);
    chk("r1_out_hold", out, 8'hFF);

    // Step gaps, DP=03
    gap_pat = 13'b1_1011_0101_1001; // bit i = step in gap cycle i (8 ones)
    DP = 8'h03; SI = 1'b0; step = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    qm = 8'h03; cm = 4'd8;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("gap_q0_%0d", i), q0, qm[0]);
      chk($sformatf("gap_count_%0d", i), count, cm);
      chk($sformatf("gap_done_%0d", i), done, 0);
      step = gap_pat[i];
      tick();
      if (gap_pat[i]) begin
        qm = {1'b0, qm[7:1]};
        cm = cm - 4'd1;
      end
    end
    step = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_out", out, 8'h00);
    tick();

    // Reset mid-operation after 3 shifts of F0
    DP = 8'hF0; SI = 1'b0; step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_out_pre", out, 8'h1E);
    chk("mid_count_pre", count, 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", q0_valid, 0);
    #1;
    rst = 1'b1;
    DP = 8'h5A; step = 1'b0; start = 1'b1;
    tick();
    chk("mid_q0", q0, 0);
    chk("mid_valid", q0_valid, 1);
    chk("mid_out_load", out, 8'h5A);

    // Start while busy: DP=11 must not reload in SHIFT or DONE
    DP = 8'h11; SI = 1'b1; step = 1'b1; start = 1'b1;
    tick();
    chk("busy_out_step1", out, 8'hAD);
    chk("busy_count_step1", count, 7);
    for (int i = 0; i < 7; i++) tick();
    chk("busy_done", done, 1);
    chk("busy_out_done", out, 8'hFF);
    tick();
    chk("busy_idle_out", out, 8'hFF);
    chk("busy_idle_busy", busy, 0);

    // Back-to-back: start held in first IDLE cycle loads; spacing BITS+2
    SI = 1'b0;
    tick();
    cyc_a = cyc;
    start = 1'b0;
    chk("b2b_load_out", out, 8'h11);
    chk("b2b_load_q0", q0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("b2b_done_seen", seen, 1);
    tick();
    chk("b2b_idle_after_done", busy, 0);
    DP = 8'h3C; start = 1'b1;
    tick();
    cyc_b = cyc;
    start = 1'b0;
    chk("b2b_reload_out", out, 8'h3C);
    chk("b2b_reload_valid", q0_valid, 1);
    chk("b2b_spacing", cyc_b - cyc_a, BITS + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
